udp_echo_tx: RTL and testbench



---
 rtl/udp_echo_pkg.sv | 24 ++
 rtl/udp_echo_tx_if.sv | 33 +++
 rtl/udp_echo_ram.sv | 31 +++
 rtl/udp_echo_tx.sv | 199 +++++++++++++++++++
 tb/tb_udp_echo_tx.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_echo_pkg.sv
// rtl/udp_echo_pkg.sv - shared types and constants for the UDP echo transmitter
// Purpose: FSM state encoding, length width and drop-counter saturation value
//          used by udp_echo_tx and its interface.
// Ports:   none (package).
package udp_echo_pkg;

  localparam int LEN_W = 16;
  localparam logic [LEN_W-1:0] DROP_MAX = 16'hFFFF;
  localparam logic [LEN_W-1:0] LEN_ONE  = 16'd1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    WAIT_RDY = 3'd2,
    START    = 3'd3,
    SEND     = 3'd4
  } state_e;

  // Saturating increment used for the dropped-datagram counter.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == DROP_MAX) ? v : v + LEN_ONE;
  endfunction

endpackage

// File: rtl/udp_echo_tx_if.sv
// rtl/udp_echo_tx_if.sv - UDP user-side receive/transmit handshake bundle
// Purpose: groups the eth UDP user-interface signals seen by the echo source.
// Ports (signals):
//   udp_rx_data_vld/udp_rx_data/udp_rx_done/udp_rx_data_num : eth -> echo receive stream
//   tx_rdy/udp_tx_req                                       : eth -> echo transmit control
//   udp_tx_en/udp_tx_data/udp_tx_data_num                   : echo -> eth transmit
// Modports: master = eth side, slave = echo side.
interface udp_echo_tx_if;
  import udp_echo_pkg::*;

  logic             udp_rx_data_vld;
  logic [7:0]       udp_rx_data;
  logic             udp_rx_done;
  logic [LEN_W-1:0] udp_rx_data_num;
  logic             tx_rdy;
  logic             udp_tx_req;
  logic             udp_tx_en;
  logic [7:0]       udp_tx_data;
  logic [LEN_W-1:0] udp_tx_data_num;

  modport master (
    output udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
    output tx_rdy, udp_tx_req,
    input  udp_tx_en, udp_tx_data, udp_tx_data_num
  );

  modport slave (
    input  udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
    input  tx_rdy, udp_tx_req,
    output udp_tx_en, udp_tx_data, udp_tx_data_num
  );

endinterface

// File: rtl/udp_echo_ram.sv
// rtl/udp_echo_ram.sv - payload buffer, simple dual-port RAM
// Purpose: 2^ADDR_W x 8 storage, one write port and one registered read port.
// Ports:
//   clk              : clock shared by both ports
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request; rd_data updates on the next edge and
//                      holds its value while rd_en is low
module udp_echo_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/udp_echo_tx.sv
// rtl/udp_echo_tx.sv - UDP echo source: buffers one received payload and replays it
// Purpose: captures one datagram from the eth UDP receive stream, checks its
//          length, then sends it back on the eth transmit request/data handshake.
// Ports:
//   clk, rst_n : UDP user-interface clock, asynchronous active-low reset
//   udp        : udp_echo_tx_if.slave bundle (receive stream, tx_rdy/req, tx outputs)
//   busy       : buffer holds or is sending a payload
//   drop_cnt   : dropped-datagram counter, saturating at 16'hFFFF
// Build option: define UDP_ECHO_TIMEOUT_EN to abort a send after TO_CYCLES
//               cycles without a udp_tx_req.
module udp_echo_tx
  import udp_echo_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_LEN   = 1472,
  parameter int TO_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  udp_echo_tx_if.slave     udp,
  output logic             busy,
  output logic [LEN_W-1:0] drop_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             tx_en_q, tx_en_d;
  logic [LEN_W-1:0] tx_num_q, tx_num_d;
  logic             busy_q, busy_d;
  // Forces udp_tx_data to zero: set by reset and by requests outside a send.
  logic             zero_q, zero_d;

  logic             ram_we;
  logic             ram_re;
  logic [7:0]       ram_rd_data;
  logic             drop_inc;

`ifdef UDP_ECHO_TIMEOUT_EN
  localparam logic [LEN_W-1:0] TO_LAST = LEN_W'(TO_CYCLES - 1);
  logic [LEN_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES != 0);
`endif

  udp_echo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_cnt_q[ADDR_W-1:0]),
    .wr_data (udp.udp_rx_data),
    .rd_en   (ram_re),
    .rd_addr (rd_cnt_q[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    tx_num_d = tx_num_q;
    zero_d   = zero_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    drop_inc = 1'b0;
`ifdef UDP_ECHO_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif

    case (state_q)
      IDLE, RECV: begin
        // wr_cnt is zero in IDLE, so both states share the capture path.
        if (udp.udp_rx_data_vld) begin
          if (wr_cnt_q == MAX_LEN_L) begin
            ovf_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + LEN_ONE;
          end
        end
        // The length check sees a byte arriving in the done cycle.
        if (udp.udp_rx_done) begin
          if (!ovf_d && (wr_cnt_d != '0) && (udp.udp_rx_data_num == wr_cnt_d)) begin
            len_d   = wr_cnt_d;
            state_d = WAIT_RDY;
          end else begin
            drop_inc = 1'b1;
            wr_cnt_d = '0;
            ovf_d    = 1'b0;
            state_d  = IDLE;
          end
        end else if (udp.udp_rx_data_vld) begin
          state_d = RECV;
        end
      end

      WAIT_RDY: begin
        if (udp.tx_rdy) begin
          tx_num_d = len_q;
          state_d  = START;
        end
      end

      START: begin
        state_d = SEND;
`ifdef UDP_ECHO_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end

      SEND: begin
        if (udp.udp_tx_req) begin
          ram_re   = 1'b1;
          rd_cnt_d = rd_cnt_q + LEN_ONE;
`ifdef UDP_ECHO_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (rd_cnt_q == len_q - LEN_ONE) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            state_d  = IDLE;
          end
        end
`ifdef UDP_ECHO_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          drop_inc = 1'b1;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + LEN_ONE;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    // While the buffer is occupied every completed datagram is lost.
    if ((state_q == WAIT_RDY || state_q == START || state_q == SEND) && udp.udp_rx_done) begin
      drop_inc = 1'b1;
    end

    if (udp.udp_tx_req) begin
      zero_d = (state_q != SEND);
    end

    drop_cnt_d = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;
    tx_en_d    = (state_d == START);
    busy_d     = (state_d == WAIT_RDY) || (state_d == START) || (state_d == SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      tx_num_q   <= '0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b1;
`ifdef UDP_ECHO_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      tx_en_q    <= tx_en_d;
      tx_num_q   <= tx_num_d;
      busy_q     <= busy_d;
      zero_q     <= zero_d;
`ifdef UDP_ECHO_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign udp.udp_tx_en       = tx_en_q;
  assign udp.udp_tx_data_num = tx_num_q;
  assign udp.udp_tx_data     = zero_q ? 8'h00 : ram_rd_data;
  assign busy                = busy_q;
  assign drop_cnt            = drop_cnt_q;

endmodule

// File: tb/tb_udp_echo_tx.sv
// tb/tb_udp_echo_tx.sv - self-checking bench for udp_echo_tx
module tb_udp_echo_tx;

  localparam int MAX_LEN = 1472;
  localparam int TO_LIM  = 100;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks;
  int errors;
  int exp_drop;

  bq_t pa;
  bq_t pb;

  udp_echo_tx_if u_if ();

  udp_echo_tx #(
    .ADDR_W    (11),
    .MAX_LEN   (MAX_LEN),
    .TO_CYCLES (TO_LIM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .udp      (u_if.slave),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference rule: a datagram is echoed iff the buffer is free, it has
  // 1..MAX_LEN bytes and eth reports exactly that many.
  function automatic bit model_accepts(input int n, input int num, input bit occupied);
    return !occupied && (n > 0) && (n <= MAX_LEN) && (num == n);
  endfunction

  task automatic send_dgram(input bq_t pl, input int num, input bit merge);
    u_if.udp_rx_data_num = 16'(num);
    for (int i = 0; i < pl.size(); i++) begin
      @(posedge clk); #1;
      u_if.udp_rx_data_vld = 1'b1;
      u_if.udp_rx_data     = pl[i];
      u_if.udp_rx_done     = merge && (i == pl.size() - 1);
    end
    if (!merge || pl.size() == 0) begin
      @(posedge clk); #1;
      u_if.udp_rx_data_vld = 1'b0;
      u_if.udp_rx_done     = 1'b1;
    end
    @(posedge clk); #1;
    u_if.udp_rx_data_vld = 1'b0;
    u_if.udp_rx_done     = 1'b0;
    u_if.udp_rx_data     = 8'h00;
  endtask

  // Returns the number of negedges until udp_tx_en is seen (0 if never).
  task automatic wait_tx_en(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (u_if.udp_tx_en === 1'b1) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) check("tx_en_seen", u_if.udp_tx_en, 1);
  endtask

  task automatic expect_echo(input bq_t ex, input bit chk_lat);
    int   cyc;
    int   nxt;
    int   prev;
    int   cur;
    bit   seen;
    logic [7:0] last;
    wait_tx_en(cyc);
    if (cyc == 0) return;
    if (chk_lat) check("tx_en_latency", cyc, 2);
    check("tx_data_num", u_if.udp_tx_data_num, ex.size());
    check("busy_start", busy, 1);
    nxt  = 0;
    prev = -1;
    seen = 0;
    last = 8'h00;
    for (int c = 0; c < ex.size() * 8 + 50; c++) begin
      if (nxt >= ex.size() && prev < 0) break;
      @(posedge clk); #1;
      if (nxt < ex.size() && $urandom_range(0, 3) != 0) begin
        u_if.udp_tx_req = 1'b1;
        cur = nxt;
        nxt++;
      end else begin
        u_if.udp_tx_req = 1'b0;
        cur = -1;
      end
      @(negedge clk);
      if (prev >= 0) begin
        check("tx_data", u_if.udp_tx_data, ex[prev]);
        last = ex[prev];
        seen = 1;
      end else if (seen) begin
        check("tx_data_hold", u_if.udp_tx_data, last);
      end
      if (prev < int'(ex.size()) - 1) begin
        check("tx_data_num_hold", u_if.udp_tx_data_num, ex.size());
        check("tx_en_once", u_if.udp_tx_en, 0);
      end
      prev = cur;
    end
    check("all_bytes_sent", nxt, ex.size());
    check("busy_after_send", busy, 0);
    check("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic expect_no_echo(input int ncyc);
    bit saw;
    saw = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (u_if.udp_tx_en !== 1'b0) saw = 1;
    end
    check("no_tx_en", saw, 0);
    check("busy_idle", busy, 0);
    check("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, u_if.udp_tx_en, 0);
    check({tag, "_tx_data"}, u_if.udp_tx_data, 0);
    check({tag, "_tx_data_num"}, u_if.udp_tx_data_num, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    int cyc;
    int n;
    int num;
    bit merge;

    checks   = 0;
    errors   = 0;
    exp_drop = 0;
    rst_n    = 1'b0;
    u_if.udp_rx_data_vld = 1'b0;
    u_if.udp_rx_data     = 8'h00;
    u_if.udp_rx_done     = 1'b0;
    u_if.udp_rx_data_num = 16'h0000;
    u_if.tx_rdy          = 1'b1;
    u_if.udp_tx_req      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 8-byte datagram 01..08
    pa = {};
    for (int i = 0; i < 8; i++) pa.push_back(8'(i + 1));
    send_dgram(pa, 8, 0);
    expect_echo(pa, 1);

    // length disagrees with eth's count
    send_dgram(pa, 9, 0);
    exp_drop++;
    expect_no_echo(10);

    // done with no bytes
    pb = {};
    send_dgram(pb, 0, 0);
    exp_drop++;
    expect_no_echo(5);

    // one byte over MAX_LEN, then a short datagram
    pa = rand_payload(MAX_LEN + 1);
    send_dgram(pa, MAX_LEN + 1, 0);
    exp_drop++;
    expect_no_echo(5);
    pa = rand_payload(4);
    send_dgram(pa, 4, 0);
    expect_echo(pa, 1);

    // exactly MAX_LEN bytes
    pa = rand_payload(MAX_LEN);
    send_dgram(pa, MAX_LEN, 1);
    expect_echo(pa, 1);

    // second datagram while the first waits for tx_rdy
    u_if.tx_rdy = 1'b0;
    pa = rand_payload(5);
    pb = rand_payload(3);
    send_dgram(pa, 5, 0);
    repeat (3) @(negedge clk);
    check("busy_wait_rdy", busy, 1);
    check("tx_en_wait_rdy", u_if.udp_tx_en, 0);
    send_dgram(pb, 3, 0);
    exp_drop++;
    @(negedge clk);
    check("drop_while_busy", drop_cnt, exp_drop);
    check("busy_still", busy, 1);
    @(posedge clk); #1;
    u_if.tx_rdy = 1'b1;
    expect_echo(pa, 0);

    // last byte and done in the same cycle
    pa = '{8'hAA, 8'hBB, 8'hCC};
    send_dgram(pa, 3, 1);
    expect_echo(pa, 1);

    // request outside a send returns zero
    @(posedge clk); #1;
    u_if.udp_tx_req = 1'b1;
    @(posedge clk); #1;
    u_if.udp_tx_req = 1'b0;
    @(negedge clk);
    check("stray_req_zero", u_if.udp_tx_data, 0);

    // reset in the middle of a send
    pa = rand_payload(6);
    send_dgram(pa, 6, 0);
    wait_tx_en(cyc);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      u_if.udp_tx_req = 1'b1;
      @(posedge clk); #1;
      u_if.udp_tx_req = 1'b0;
      @(negedge clk);
      check("pre_reset_data", u_if.udp_tx_data, pa[i]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_drop = 0;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_no_tx_en", u_if.udp_tx_en, 0);
    rst_n = 1'b1;
    pb = rand_payload(2);
    send_dgram(pb, 2, 0);
    expect_echo(pb, 1);

    // randomized datagrams against the reference rule
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 24);
      num = n;
      if ($urandom_range(0, 3) == 0) num = ($urandom_range(0, 1) == 0) ? n + 1 : n - 1;
      merge = 1'($urandom_range(0, 1));
      pa = rand_payload(n);
      send_dgram(pa, num, merge);
      if (model_accepts(n, num, 0)) begin
        expect_echo(pa, 1);
      end else begin
        exp_drop++;
        expect_no_echo(6);
      end
    end

`ifdef UDP_ECHO_TIMEOUT_EN
    // no requests after udp_tx_en: abort after TO_LIM cycles in SEND
    pa = rand_payload(3);
    send_dgram(pa, 3, 0);
    wait_tx_en(cyc);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    exp_drop++;
    check("timeout_cycles", n, TO_LIM);
    check("timeout_drop", drop_cnt, exp_drop);
    check("timeout_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
